// File: rtl/mic_pkg.sv
// Shared widths, configuration payload and helpers for the PDM microphone front end.
package mic_pkg;

    localparam int unsigned NUM_LINES   = 20;
    localparam int unsigned NUM_CH      = 2 * NUM_LINES;
    localparam int unsigned DIV_W       = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned MIN_DIV     = SYNC_STAGES + 2;

    typedef struct packed {
        logic [DIV_W-1:0]  clk_div;
        logic [DIV_W-1:0]  cic_osr;
        logic [NUM_CH-1:0] ch_en;
    } mic_fe_cfg_t;

    // Half period must cover the synchronizer plus the capture flop.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
        return (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
    endfunction

    function automatic logic [NUM_CH-1:0] pack_slots(input logic [NUM_LINES-1:0] rise,
                                                     input logic [NUM_LINES-1:0] fall);
        logic [NUM_CH-1:0] bits;
        bits = '0;
        for (int i = 0; i < int'(NUM_LINES); i++) begin
            bits[2*i]   = rise[i];
            bits[2*i+1] = fall[i];
        end
        return bits;
    endfunction

endpackage

// File: rtl/mic_sync.sv
// Multi-stage flop chain bringing asynchronous PDM data into the ipg_clk domain.
module mic_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/mic_pdm_frontend.sv
// PDM clock generation, stereo slot capture and decimator clock-gate enables.
module mic_pdm_frontend
    import mic_pkg::*;
(
    input  logic                 ipg_clk,
    input  logic                 ipg_hard_async_reset,
    input  logic                 mic_enable,
    input  logic [DIV_W-1:0]     clk_div,
    input  logic [DIV_W-1:0]     cic_osr,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic [NUM_LINES-1:0] pdm_data,
    output logic                 pdm_clk,
    output logic [NUM_CH-1:0]    pdm_bits,
    output logic                 pdm_valid,
    output logic                 dec_en,
    output logic                 dec16_en
);

    localparam int unsigned D16_W = 4;

    logic                 en_q;
    mic_fe_cfg_t          cfg;
    logic [NUM_LINES-1:0] sync_data;
    logic [DIV_W-1:0]     hcnt;
    logic [DIV_W-1:0]     ocnt;
    logic [D16_W-1:0]     d16cnt;
    logic [NUM_LINES-1:0] fall_cap;
    logic                 had_high;
    logic                 fall_valid;

    logic run;
    logic half_end;
    logic strobe;
    logic osr_wrap;

    mic_sync #(
        .WIDTH  (NUM_LINES),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (ipg_clk),
        .rst (ipg_hard_async_reset),
        .d   (pdm_data),
        .q   (sync_data)
    );

    // The enable edge itself is a setup cycle; counting starts on the cycle after.
    assign run      = mic_enable & en_q;
    assign half_end = run & (hcnt == (cfg.clk_div - DIV_W'(1)));
    assign strobe   = half_end & pdm_clk & fall_valid;
    assign osr_wrap = (ocnt == (cfg.cic_osr - DIV_W'(1)));

    always_ff @(posedge ipg_clk or posedge ipg_hard_async_reset) begin
        if (ipg_hard_async_reset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= mic_enable;
        end
    end

    // Configuration is sampled only on the rising edge of mic_enable.
    always_ff @(posedge ipg_clk or posedge ipg_hard_async_reset) begin
        if (ipg_hard_async_reset) begin
            cfg <= '0;
        end else if (mic_enable && !en_q) begin
            cfg.clk_div <= clamp_div(clk_div);
            cfg.cic_osr <= (cic_osr == '0) ? DIV_W'(1) : cic_osr;
            cfg.ch_en   <= ch_en;
        end
    end

    always_ff @(posedge ipg_clk or posedge ipg_hard_async_reset) begin
        if (ipg_hard_async_reset) begin
            hcnt    <= '0;
            pdm_clk <= 1'b0;
        end else if (!run) begin
            hcnt    <= '0;
            pdm_clk <= 1'b0;
        end else if (half_end) begin
            hcnt    <= '0;
            pdm_clk <= ~pdm_clk;
        end else begin
            hcnt <= hcnt + DIV_W'(1);
        end
    end

    // The falling-slot mic only drives valid data after it has seen a falling edge,
    // so the first low phase is discarded and each strobe pairs a fall with the next rise.
    always_ff @(posedge ipg_clk or posedge ipg_hard_async_reset) begin
        if (ipg_hard_async_reset) begin
            fall_cap   <= '0;
            had_high   <= 1'b0;
            fall_valid <= 1'b0;
            pdm_bits   <= '0;
            pdm_valid  <= 1'b0;
        end else begin
            pdm_valid <= strobe;
            if (!run) begin
                had_high   <= 1'b0;
                fall_valid <= 1'b0;
            end else if (half_end) begin
                if (pdm_clk) begin
                    had_high <= 1'b1;
                    if (strobe) begin
                        pdm_bits <= pack_slots(sync_data, fall_cap) & cfg.ch_en;
                    end
                end else begin
                    fall_cap   <= sync_data;
                    fall_valid <= had_high;
                end
            end
        end
    end

    always_ff @(posedge ipg_clk or posedge ipg_hard_async_reset) begin
        if (ipg_hard_async_reset) begin
            ocnt   <= '0;
            dec_en <= 1'b0;
        end else begin
            dec_en <= strobe & osr_wrap;
            if (!run) begin
                ocnt <= '0;
            end else if (strobe) begin
                ocnt <= osr_wrap ? '0 : ocnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge ipg_clk or posedge ipg_hard_async_reset) begin
        if (ipg_hard_async_reset) begin
            d16cnt   <= '0;
            dec16_en <= 1'b0;
        end else begin
            dec16_en <= strobe & osr_wrap & (d16cnt == '1);
            if (!run) begin
                d16cnt <= '0;
            end else if (strobe && osr_wrap) begin
                d16cnt <= d16cnt + D16_W'(1);
            end
        end
    end

endmodule
